// File: rtl/pb_pkg.sv
// Shared constants and types for the PicoBlaze 16-bit datapath register bank.
// Holds the default geometry, the clear-sequencer state encoding and a clog2 helper.
package pb_pkg;

  localparam int PB_WIDTH = 16;
  localparam int PB_REGS  = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pb_clr_seq.sv
// Bulk-clear sequencer: walks a flat index over every register of every bank, one per cycle.
// The current FSM state is exported for observation alongside the busy flag.
module pb_clr_seq
  import pb_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int CW      = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_we,
  output logic [CW-1:0] clr_idx,
  output clr_state_e    state
);

  localparam logic [CW-1:0] LAST_IDX = CW'(ENTRIES - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      clr_busy <= 1'b0;
      clr_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state    <= ST_CLEAR;
            clr_busy <= 1'b1;
            clr_idx  <= '0;
          end
        end
        ST_CLEAR: begin
          // The last entry is zeroed on the same edge that returns to IDLE.
          clr_idx <= clr_idx + CW'(1);
          if (clr_idx == LAST_IDX) begin
            state    <= ST_IDLE;
            clr_busy <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we = clr_busy;

endmodule

// File: rtl/pb_reg_bank.sv
// Banked register file for the 16-bit PicoBlaze datapath: one write port, two
// combinational read ports with optional write bypass, a bank select and a bulk clear.
module pb_reg_bank
  import pb_pkg::*;
#(
  parameter  int WIDTH   = PB_WIDTH,
  parameter  int DEPTH   = PB_REGS,
  parameter  int NBANKS  = 2,
  parameter  int BYPASS  = 1,
  localparam int AW      = clog2(DEPTH),
  localparam int BW      = (NBANKS > 1) ? clog2(NBANKS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_x,
  input  logic [AW-1:0]    raddr_y,
  output logic [WIDTH-1:0] rdata_x,
  output logic [WIDTH-1:0] rdata_y,
  input  logic             bank_ld,
  input  logic [BW-1:0]    bank_d,
  output logic [BW-1:0]    bank,
  input  logic             clr_req,
  output logic             clr_busy
);

  localparam int CW      = (NBANKS > 1) ? AW + BW : AW;
  localparam int ENTRIES = DEPTH * NBANKS;

  // Handshake: clr_req is a level sampled only while the sequencer is idle.
  // While clr_busy is high the clear engine owns storage: we, bank_ld and clr_req are dropped.
  logic             clr_we;
  logic [CW-1:0]    clr_idx;
  clr_state_e       clr_state;
  logic [CW-1:0]    widx;
  logic [CW-1:0]    xidx;
  logic [CW-1:0]    yidx;
  logic             wr_live;
  logic [WIDTH-1:0] mem [ENTRIES];

  pb_clr_seq #(
    .ENTRIES (ENTRIES),
    .CW      (CW)
  ) u_clr_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx),
    .state    (clr_state)
  );

  generate
    if (NBANKS > 1) begin : g_banked
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          bank <= '0;
        end else if (bank_ld && clr_state == ST_IDLE) begin
          bank <= bank_d;
        end
      end
      assign widx = {bank, waddr};
      assign xidx = {bank, raddr_x};
      assign yidx = {bank, raddr_y};
    end else begin : g_single
      assign bank = '0;
      assign widx = waddr;
      assign xidx = raddr_x;
      assign yidx = raddr_y;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign wr_live = we && !clr_busy;

  always_comb begin
    rdata_x = mem[xidx];
    rdata_y = mem[yidx];
    if (BYPASS != 0 && wr_live) begin
      if (waddr == raddr_x) rdata_x = wdata;
      if (waddr == raddr_y) rdata_y = wdata;
    end
  end

endmodule

// File: tb/tb_pb_reg_bank.sv
// Directed bench for pb_reg_bank: a bypassing and a non-bypassing instance share stimulus,
// expected values come from a small register model through a scoreboard queue.
module tb_pb_reg_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic [3:0]  raddr_x = '0;
  logic [3:0]  raddr_y = '0;
  logic        bank_ld = 1'b0;
  logic        bank_d = 1'b0;
  logic        clr_req = 1'b0;

  logic [15:0] rdata_x, rdata_y, rdata_x_nb, rdata_y_nb;
  logic        bank, bank_nb, clr_busy, clr_busy_nb;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mdl [32];
  logic        bank_m = 1'b0;

  pb_reg_bank #(.WIDTH(16), .DEPTH(16), .NBANKS(2), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_x(raddr_x), .raddr_y(raddr_y), .rdata_x(rdata_x), .rdata_y(rdata_y),
    .bank_ld(bank_ld), .bank_d(bank_d), .bank(bank),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  pb_reg_bank #(.WIDTH(16), .DEPTH(16), .NBANKS(2), .BYPASS(0)) u_dut_nb (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_x(raddr_x), .raddr_y(raddr_y), .rdata_x(rdata_x_nb), .rdata_y(rdata_y_nb),
    .bank_ld(bank_ld), .bank_d(bank_d), .bank(bank_nb),
    .clr_req(clr_req), .clr_busy(clr_busy_nb)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver and scoreboard tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%h expected=none_queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic model_clear;
    for (int i = 0; i < 32; i++) mdl[i] = 16'h0000;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    we = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    we = 1'b0;
    mdl[{bank_m, a}] = d;
  endtask

  task automatic set_bank(input logic b);
    bank_ld = 1'b1;
    bank_d = b;
    tick();
    bank_ld = 1'b0;
    bank_m = b;
    exp_q.push_back({15'd0, b});
    check("bank_sel", {15'd0, bank});
  endtask

  task automatic rd(input string tag, input logic [3:0] a);
    logic [3:0] ya;
    ya = ~a;
    raddr_x = a;
    raddr_y = ya;
    #1;
    exp_q.push_back(mdl[{bank_m, a}]);
    check({tag, "_x"}, rdata_x);
    exp_q.push_back(mdl[{bank_m, ya}]);
    check({tag, "_y"}, rdata_y);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 16; a++) rd(tag, 4'(a));
  endtask

  initial begin
    int n;
    model_clear();

    // 1. reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.push_back(16'd0);
    check("rst_busy", {15'd0, clr_busy});
    exp_q.push_back(16'd0);
    check("rst_bank", {15'd0, bank});
    sweep("rst_b0");
    set_bank(1'b1);
    sweep("rst_b1");
    set_bank(1'b0);

    // 2. banked writes to r3
    wr(4'd3, 16'h1234);
    set_bank(1'b1);
    wr(4'd3, 16'hBEEF);
    rd("b1_r3", 4'd3);
    set_bank(1'b0);
    rd("b0_r3", 4'd3);

    // 3. same-cycle bypass vs old value
    we = 1'b1;
    waddr = 4'd5;
    wdata = 16'hA5A5;
    raddr_x = 4'd5;
    raddr_y = 4'd5;
    #1;
    exp_q.push_back(16'hA5A5);
    check("byp_x", rdata_x);
    exp_q.push_back(16'hA5A5);
    check("byp_y", rdata_y);
    exp_q.push_back(16'h0000);
    check("nobyp_x", rdata_x_nb);
    exp_q.push_back(16'h0000);
    check("nobyp_y", rdata_y_nb);
    tick();
    we = 1'b0;
    mdl[{bank_m, 4'd5}] = 16'hA5A5;
    rd("after_byp", 4'd5);

    // 4. fill, clear, dropped write and bank_ld during clear
    for (int b = 0; b < 2; b++) begin
      set_bank(b[0]);
      for (int a = 0; a < 16; a++) wr(4'(a), 16'($urandom_range(1, 16'hFFFF)));
    end
    sweep("fill_b1");
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy && n < 100) begin
      n++;
      we = (n == 25);
      waddr = 4'd0;
      wdata = 16'hFFFF;
      bank_ld = (n == 10);
      bank_d = 1'b0;
      tick();
    end
    we = 1'b0;
    bank_ld = 1'b0;
    model_clear();
    exp_q.push_back(16'd32);
    check("clr_cycles", 16'(n));
    exp_q.push_back(16'd1);
    check("clr_bank_hold", {15'd0, bank});
    sweep("clr_b1");
    set_bank(1'b0);
    sweep("clr_b0");

    // 5. reset in the middle of a clear
    set_bank(1'b1);
    wr(4'd2, 16'h5555);
    set_bank(1'b0);
    wr(4'd9, 16'h9999);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (9) tick();
    exp_q.push_back(16'd1);
    check("mid_busy", {15'd0, clr_busy});
    reset = 1'b1;
    #1;
    model_clear();
    bank_m = 1'b0;
    exp_q.push_back(16'd0);
    check("async_busy", {15'd0, clr_busy});
    exp_q.push_back(16'd0);
    check("async_bank", {15'd0, bank});
    sweep("async_b0");
    tick();
    reset = 1'b0;
    wr(4'd4, 16'h7777);
    rd("post_rst_wr", 4'd4);
    set_bank(1'b1);
    sweep("post_rst_b1");

    // 6. same-edge write and bank load
    wr(4'd7, 16'hC3C3);
    set_bank(1'b0);
    we = 1'b1;
    waddr = 4'd7;
    wdata = 16'h0F0F;
    bank_ld = 1'b1;
    bank_d = 1'b1;
    tick();
    we = 1'b0;
    bank_ld = 1'b0;
    mdl[{1'b0, 4'd7}] = 16'h0F0F;
    bank_m = 1'b1;
    exp_q.push_back(16'd1);
    check("same_edge_bank", {15'd0, bank});
    rd("same_edge_b1", 4'd7);
    set_bank(1'b0);
    rd("same_edge_b0", 4'd7);
    raddr_x = 4'd7;
    #1;
    exp_q.push_back(16'h0F0F);
    check("nb_same_edge", rdata_x_nb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
